// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default sizing.
package intc_pkg;

    localparam int DEF_N_CH     = 4;
    localparam int DEF_NUM_W    = 3;
    localparam int DEF_BASE_NUM = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module intc_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the last hit, the lowest set index, wins.
    always_comb begin
        // NOTE: default first so every path assigns idx_o and no latch is inferred.
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/intc_ctrl.sv
// Nested, edge-triggered interrupt controller presenting one vector at a time.
module intc_ctrl
    import intc_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int NUM_W    = DEF_NUM_W,
    parameter int BASE_NUM = DEF_BASE_NUM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  irq_in,
    input  logic             if_set,
    input  logic             if_clear,
    input  logic             mask_we,
    input  logic [N_CH-1:0]  mask_wdata,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [NUM_W-1:0] int_num,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  in_service,
    output logic [N_CH-1:0]  mask,
    output logic             if_out
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [N_CH-1:0] BIT0 = N_CH'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [N_CH-1:0]    irq_prev_q;
    logic [N_CH-1:0]    pending_q, pending_d;
    logic [N_CH-1:0]    in_service_q, in_service_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic               if_q, if_d;

    logic [IDX_W-1:0]   cand_idx, top_idx;
    logic               cand_valid, top_valid;
    logic [N_CH-1:0]    edge_v, sel_bit, top_bit, ack_bit, ret_bit;
    logic               eligible, withdraw, accept;

    intc_prio_enc #(.N(N_CH), .IDX_W(IDX_W)) u_cand_enc (
        .req_i   (pending_q & ~mask_q),
        .idx_o   (cand_idx),
        .valid_o (cand_valid)
    );

    intc_prio_enc #(.N(N_CH), .IDX_W(IDX_W)) u_top_enc (
        .req_i   (in_service_q),
        .idx_o   (top_idx),
        .valid_o (top_valid)
    );

    assign edge_v   = irq_in & ~irq_prev_q;
    assign sel_bit  = BIT0 << sel_q;
    assign top_bit  = BIT0 << top_idx;
    // A candidate may only preempt work of strictly lower priority.
    assign eligible = if_q && cand_valid && (!top_valid || (cand_idx < top_idx));
    // Withdrawal is judged on the write data so the request drops the next cycle.
    assign withdraw = if_clear || (mask_we && |(mask_wdata & sel_bit));

    // Next-state logic: latch the winner on entry, hold it until ack or withdrawal.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_REQ;
                    sel_d   = cand_idx;
                end
            end
            ST_REQ: begin
                if (withdraw) begin
                    state_d = ST_IDLE;
                end else if (int_ack) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register next-state: return clears before ack sets, and a fresh edge beats the ack clear.
    always_comb begin
        ack_bit      = accept ? sel_bit : '0;
        ret_bit      = (int_ret && top_valid) ? top_bit : '0;
        pending_d    = (pending_q & ~ack_bit) | edge_v;
        in_service_d = (in_service_q & ~ret_bit) | ack_bit;
        mask_d       = mask_we ? mask_wdata : mask_q;
        if (if_clear || accept) begin
            if_d = 1'b0;
        end else if (if_set || int_ret) begin
            if_d = 1'b1;
        end else begin
            if_d = if_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Controller registers; irq_prev clears so a line held high through reset yields one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            if_q         <= 1'b0;
        end else begin
            irq_prev_q   <= irq_in;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            if_q         <= if_d;
        end
    end

    assign int_req    = (state_q == ST_REQ);
    assign int_num    = int_req ? (NUM_W'(BASE_NUM) + NUM_W'(sel_q)) : '0;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;
    assign if_out     = if_q;

endmodule
